gauss_cascade_stream: RTL
=========================

Name: gauss_cascade_stream

Overview:
- Parametrised successor to the two-stage Gaussian wrapper.
- Cascades NUM_STAGES GAUSSIAN instances, gated by accepted input pixels.
- Suppresses output until the filter pipeline is primed (warm-up count), then buffers filtered pixels in an internal FIFO read by the up sampler.
- New behaviour:
  - Real backpressure toward the down sampler (no silent FIFO overflow).
  - Start-of-frame re-priming.
  - Occupancy and status outputs.

Parameters:
- PIX_W, 8: pixel width in bits (din, dout, inter-stage buses).
- NUM_STAGES, 2: number of cascaded GAUSSIAN stages, 1..4.
- WARMUP, 1612: accepted pixels before the first valid filtered output (full cascade priming).
- CNT_W, 11: warm-up counter width; must satisfy 2^CNT_W > WARMUP.
- FIFO_DEPTH, 16: output FIFO entries, power of two, at least 2.
- AW, 4: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame pulse; restarts warm-up.
- valid  in  1  upstream pixel valid.
- din  in  PIX_W  upstream pixel.
- ready_down  out  1  block can accept a pixel this cycle.
- rd_en_down  out  1  pixel accepted this cycle (valid & ready_down).
- rd_en_up  in  1  up-sampler read request.
- valid_out  out  1  dout valid (one cycle after accepted read).
- dout  out  PIX_W  filtered pixel.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- fifo_count  out  AW+1  FIFO occupancy 0..FIFO_DEPTH.
- primed  out  1  warm-up complete; block is in STREAM state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM to WARMUP, counter to 0, FIFO pointers and count to 0.
  - valid_out=0, dout=0, empty=1, full=0, fifo_count=0, primed=0.
  - GAUSSIAN stages receive rst = ~rst_n.
- Accept:
  - ready_down = ~full (registered-state based, no combinational path from rd_en_up).
  - accept = valid & ready_down; rd_en_down = accept.
  - GAUSSIAN clk_en for every stage = accept; pixels shift only on accept.
  - Stage k din = stage k-1 dout; stage 0 din = din.
- FSM WARMUP:
  - Each accept increments the counter.
  - When accept and counter == WARMUP-1, counter saturates at WARMUP; go to STREAM next cycle.
  - No FIFO writes occur in WARMUP.
- FSM STREAM:
  - primed=1.
  - FIFO write = accept; data = last-stage dout sampled the same cycle.
  - The counter holds at WARMUP.
- sof:
  - sof=1 in any state: next state WARMUP, counter cleared.
  - sof coincident with accept: that pixel counts as pixel 1 (counter=1).
  - The FIFO is not flushed; already-buffered pixels remain readable.
- FIFO:
  - Synchronous circular buffer.
  - Read accepted when rd_en_up & ~empty: dout and valid_out update the next cycle.
  - valid_out is a single-cycle pulse per read.
  - rd_en_up while empty is ignored: valid_out=0, dout holds its last value.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - full/empty/fifo_count are registered and consistent every cycle.
  - Write cannot occur when full because ready_down=0.
- Pointer wrap: pointers are AW bits and wrap modulo FIFO_DEPTH. Count arithmetic is in AW+1 bits.
- Latency: pixel accepted in cycle t (STREAM) is readable from cycle t+1; earliest valid_out at t+2.

Optional Feature:
- Macro: GAUSS_CASCADE_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - When bypass=1, FIFO write = accept and FIFO data = din regardless of FSM state; warm-up is ignored.
  - Stages still shift on accept; the counter still runs, so clearing bypass mid-frame resumes correct behaviour.
  - primed stays FSM-driven.
- When undefined: no bypass port; behaviour exactly as above.

Test Plan:
- Reset, then 1612 valid pixels with rd_en_up=0 -> empty=1 throughout, primed rises the cycle after pixel 1612; pixel 1613 -> fifo_count=1.
- Primed, 20 valid pixels, rd_en_up=0, FIFO_DEPTH=16:
  - ready_down drops after the 16th write; full=1, fifo_count=16.
  - rd_en_down=0 for the remaining 4; no data lost.
  - Then 16 reads return the buffered values in order.
- Primed, continuous valid plus continuous rd_en_up -> fifo_count stays at 1, valid_out every cycle, data matches the reference model of NUM_STAGES Gaussian passes.
- sof during STREAM with fifo_count=5 -> primed=0 next cycle, 5 old pixels still read out, no new writes until 1612 more accepts.
- rst_n pulsed low mid-stream, asynchronously between clock edges -> all outputs at reset values immediately; fifo_count=0, empty=1.
- With GAUSS_CASCADE_BYPASS_EN, bypass=1 after reset, din=0x3C -> written immediately; read gives dout=0x3C, valid_out=1 two cycles after accept.

Source files
------------

// File: rtl/gauss_cascade_stream.sv
// gauss_cascade_stream: NUM_STAGES cascaded 3-tap binomial (GAUSSIAN) stages clocked by accepted
// pixels, warm-up suppression with sof re-priming, and a backpressured output FIFO.
// Optional feature macro: GAUSS_CASCADE_BYPASS_EN (adds a bypass input that routes din straight to the FIFO).

module GAUSSIAN #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] tap1_q, tap2_q, dout_q;
  logic [PIX_W+1:0] sum;
  logic [PIX_W-1:0] dout_d;

  // [1 2 1]/4 kernel with round-half-up; the sum cannot exceed 4*max+2, so PIX_W+2 bits suffice.
  assign sum    = {2'b00, din} + {1'b0, tap1_q, 1'b0} + {2'b00, tap2_q} + (PIX_W+2)'(2);
  assign dout_d = PIX_W'(sum >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap1_q <= '0;
      tap2_q <= '0;
      dout_q <= '0;
    end else if (clk_en) begin
      tap1_q <= din;
      tap2_q <= tap1_q;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

module gauss_cascade_stream #(
  parameter int PIX_W      = 8,
  parameter int NUM_STAGES = 2,
  parameter int WARMUP     = 1612,
  parameter int CNT_W      = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid,
  input  logic [PIX_W-1:0] din,
`ifdef GAUSS_CASCADE_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             ready_down,
  output logic             rd_en_down,
  input  logic             rd_en_up,
  output logic             valid_out,
  output logic [PIX_W-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      fifo_count,
  output logic             primed
);

  typedef enum logic {
    S_WARMUP = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             validOut_q;
  logic [PIX_W-1:0] dout_q;
  logic [PIX_W-1:0] mem [FIFO_DEPTH];

  logic             accept;
  logic             fifoWr, fifoRd;
  logic             bypassOn;
  logic [PIX_W-1:0] wrData;
  logic [PIX_W-1:0] stageBus [NUM_STAGES+1];

`ifdef GAUSS_CASCADE_BYPASS_EN
  assign bypassOn = bypass;
`else
  assign bypassOn = 1'b0;
`endif

  // Backpressure depends only on registered FIFO state, never on rd_en_up.
  assign ready_down = ~full_q;
  assign accept     = valid & ~full_q;
  assign rd_en_down = accept;

  assign stageBus[0] = din;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
    GAUSSIAN #(.PIX_W(PIX_W)) uStage (
      .clk    (clk),
      .rst    (~rst_n),
      .clk_en (accept),
      .din    (stageBus[k]),
      .dout   (stageBus[k+1])
    );
  end

  // sof restarts the frame first, so a coincident accept becomes pixel 1 of the new frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sof) begin
      state_d = S_WARMUP;
      cnt_d   = '0;
    end
    if (accept && (state_d == S_WARMUP)) begin
      if (cnt_d == CNT_W'(WARMUP - 1)) begin
        cnt_d   = CNT_W'(WARMUP);
        state_d = S_STREAM;
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WARMUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign primed = (state_q == S_STREAM);

  assign fifoWr = accept & (bypassOn | ((state_q == S_STREAM) & ~sof));
  assign fifoRd = rd_en_up & ~empty_q;
  assign wrData = bypassOn ? din : stageBus[NUM_STAGES];

  always_comb begin
    count_d = count_q;
    case ({fifoWr, fifoRd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifoWr) begin
      mem[wrPtr_q] <= wrData;
    end
  end

  // Flags are re-registered from the next count so they always agree with fifo_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      validOut_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      if (fifoWr) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (fifoRd) begin
        rdPtr_q <= rdPtr_q + AW'(1);
        dout_q  <= mem[rdPtr_q];
      end
      count_q    <= count_d;
      full_q     <= (count_d == (AW+1)'(FIFO_DEPTH));
      empty_q    <= (count_d == '0);
      validOut_q <= fifoRd;
    end
  end

  assign valid_out  = validOut_q;
  assign dout       = dout_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign fifo_count = count_q;

endmodule
